// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory responder.
//   SIZE_*       request size encodings carried on ReqSize
//   MAX_LATENCY  largest supported request-to-response latency
//   state_e      responder FSM states
package dmem_pkg;

    localparam logic [1:0] SIZE_BYTE    = 2'b00;
    localparam logic [1:0] SIZE_HWORD   = 2'b01;
    localparam logic [1:0] SIZE_WORD    = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    localparam int unsigned MAX_LATENCY = 15;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StWait = 2'b01,
        StResp = 2'b10
    } state_e;

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response handshake between the CPU data port and the
// memory responder.
//   master modport: requester (drives Req*, RespReady)
//   slave modport:  responder (drives ReqReady, Resp*)
interface dmem_responder_if;

    logic        ReqValid;
    logic        ReqReady;
    logic [31:0] ReqAddr;
    logic [1:0]  ReqSize;
    logic        ReqWE;
    logic [31:0] ReqData;
    logic        RespValid;
    logic        RespReady;
    logic [31:0] RespData;
    logic        RespErr;

    modport master (
        output ReqValid, ReqAddr, ReqSize, ReqWE, ReqData, RespReady,
        input  ReqReady, RespValid, RespData, RespErr
    );

    modport slave (
        input  ReqValid, ReqAddr, ReqSize, ReqWE, ReqData, RespReady,
        output ReqReady, RespValid, RespData, RespErr
    );

endinterface

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational little-endian lane steering for one 32-bit word.
//   addr_lo    in   byte offset within the word
//   size       in   request size encoding
//   wr_data    in   right-justified store data
//   rd_word    in   current contents of the addressed word
//   byte_en    out  lanes written by a store (zero when misaligned/illegal)
//   wr_word    out  rd_word with the enabled lanes replaced by store data
//   rd_data    out  addressed lanes right-justified, upper bits zero
//   align_err  out  misaligned access or illegal size
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic [31:0] wr_data,
    input  logic [31:0] rd_word,
    output logic [3:0]  byte_en,
    output logic [31:0] wr_word,
    output logic [31:0] rd_data,
    output logic        align_err
);

    // Store data replicated across all lanes; byte_en picks the live ones.
    logic [31:0] wr_rep;

    always_comb begin
        byte_en   = 4'b0000;
        rd_data   = 32'h0;
        align_err = 1'b0;
        wr_rep    = wr_data;
        case (size)
            SIZE_BYTE: begin
                byte_en = 4'b0001 << addr_lo;
                rd_data = {24'h0, rd_word[{addr_lo, 3'b000} +: 8]};
                wr_rep  = {4{wr_data[7:0]}};
            end
            SIZE_HWORD: begin
                align_err = addr_lo[0];
                byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
                rd_data   = {16'h0, rd_word[{addr_lo[1], 4'b0000} +: 16]};
                wr_rep    = {2{wr_data[15:0]}};
            end
            SIZE_WORD: begin
                align_err = |addr_lo;
                byte_en   = 4'b1111;
                rd_data   = rd_word;
            end
            default: align_err = 1'b1;
        endcase
        if (align_err) begin
            byte_en = 4'b0000;
        end
        for (int k = 0; k < 4; k++) begin
            wr_word[8*k +: 8] = byte_en[k] ? wr_rep[8*k +: 8] : rd_word[8*k +: 8];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the CPU data port with fixed latency.
//   CLK  in   clock, rising edge
//   RST  in   synchronous active-high reset
//   bus  slave modport of dmem_responder_if (request/response handshake)
// Parameters: DEPTH_WORDS (power of two), LATENCY (1..MAX_LATENCY).
// A request accepted in IDLE is committed (store written or load data registered)
// on the edge that enters RESP, LATENCY cycles after acceptance.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input logic             CLK,
    input logic             RST,
    dmem_responder_if.slave bus
);

    localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS);
    localparam logic [63:0] ADDR_LIMIT = 64'(DEPTH_WORDS) * 64'd4;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, data_q;
    logic [1:0]  size_q;
    logic        we_q;
    logic [31:0] resp_data_q, resp_data_d;
    logic        resp_err_q, resp_err_d;
    logic        commit;

    logic [31:0] mem [DEPTH_WORDS];

    // With LATENCY=1 the commit happens on the accept edge, so the live bus
    // request is used while idle and the latched copy otherwise.
    logic             idle;
    logic [31:0]      cur_addr, cur_data;
    logic [1:0]       cur_size;
    logic             cur_we;
    logic [IDX_W-1:0] word_idx;
    logic             range_err, align_err, err;
    logic [3:0]       byte_en;
    logic [31:0]      wr_word, rd_data;

    assign idle     = (state_q == StIdle);
    assign cur_addr = idle ? bus.ReqAddr : addr_q;
    assign cur_data = idle ? bus.ReqData : data_q;
    assign cur_size = idle ? bus.ReqSize : size_q;
    assign cur_we   = idle ? bus.ReqWE   : we_q;
    assign word_idx  = cur_addr[IDX_W+1:2];
    assign range_err = ({32'h0, cur_addr} >= ADDR_LIMIT);
    assign err       = range_err | align_err;

    dmem_lane_align u_align (
        .addr_lo   (cur_addr[1:0]),
        .size      (cur_size),
        .wr_data   (cur_data),
        .rd_word   (mem[word_idx]),
        .byte_en   (byte_en),
        .wr_word   (wr_word),
        .rd_data   (rd_data),
        .align_err (align_err)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.ReqValid) begin
                    cnt_d = 4'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        state_d = StResp;
                        commit  = 1'b1;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = StResp;
                    commit  = 1'b1;
                end
            end
            StResp: begin
                if (bus.RespReady) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        if (commit) begin
            resp_err_d  = err;
            resp_data_d = (!cur_we && !err) ? rd_data : 32'h0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            addr_q      <= 32'h0;
            data_q      <= 32'h0;
            size_q      <= SIZE_BYTE;
            we_q        <= 1'b0;
            resp_data_q <= 32'h0;
            resp_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
            if (idle && bus.ReqValid) begin
                addr_q <= bus.ReqAddr;
                data_q <= bus.ReqData;
                size_q <= bus.ReqSize;
                we_q   <= bus.ReqWE;
            end
        end
    end

    // RAM is not reset; reset in the commit cycle drops the store.
    always_ff @(posedge CLK) begin
        if (!RST && commit && cur_we && !err) begin
            mem[word_idx] <= wr_word;
        end
    end

    assign bus.ReqReady  = idle;
    assign bus.RespValid = (state_q == StResp);
    assign bus.RespData  = resp_data_q;
    assign bus.RespErr   = resp_err_q;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the CPU data port: accepts byte/halfword/word load and store requests over a valid/ready handshake, services them against an internal word-organized RAM after a fixed programmable latency, and returns read data right-justified with an error flag. It is the far end of the CPU's `DataAddr`/`DataSize`/`DataIn`/`DataOut`/`WE` interface and replaces the zero-latency data path when multi-cycle memory timing is modelled. Sign/zero extension of loads stays in the CPU.

## Interface
- `DEPTH_WORDS`, 1024: number of 32-bit words stored (power of two).
- `LATENCY`, 2: cycles from request acceptance to `RespValid` (1..15).
- `CLK`  in  1  clock; all state updates on rising edge.
- `RST`  in  1  reset; synchronous, active-high.
- `ReqValid`  in  1  request present.
- `ReqReady`  out  1  responder can accept a request this cycle.
- `ReqAddr`  in  32  byte address.
- `ReqSize`  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- `ReqWE`  in  1  1 = store, 0 = load.
- `ReqData`  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- `RespValid`  out  1  response present.
- `RespReady`  in  1  requester accepts response.
- `RespData`  out  32  load data right-justified, upper bits zero; 0 for stores and errors.
- `RespErr`  out  1  request was misaligned, illegal size, or out of range.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: `ReqReady`=1. On `ReqValid`: latch addr/size/WE/data, compute error, load counter with `LATENCY`-1; go WAIT (or RESP directly if `LATENCY`=1).
- WAIT: `ReqReady`=0; counter decrements each cycle; when counter is 1 go RESP.
- On WAIT→RESP (or IDLE→RESP) edge: if no error, perform the store (byte-enabled write) or register the read data into `RespData`; set `RespErr`.
- RESP: `RespValid`=1, outputs held stable until `RespReady`=1; then go IDLE, `RespValid`=0.
- Error when: `ReqSize`=11; halfword with addr[0]=1; word with addr[1:0]≠00; `ReqAddr` ≥ 4·`DEPTH_WORDS`. Errored store writes nothing; errored load returns `RespData`=0.
- Lane select: word index = addr[log2(DEPTH_WORDS)+1:2]. Byte lane addr[1:0] (bits 8·k+7:8·k); half lane addr[1] (bits 16·h+15:16·h). Little-endian.
- Stores touch only the addressed lanes; other bytes of the word unchanged.
- RAM contents are not reset and power up as X; benches preload.

## Timing
- Reset values: state IDLE, `ReqReady`=1, `RespValid`=0, `RespData`=0, `RespErr`=0, counter 0.
- Request accepted on edge where `ReqValid`&&`ReqReady`; `RespValid` rises exactly `LATENCY` edges later.
- Store data visible to a subsequent load request accepted any time after the response edge.
- No overlap: `ReqReady`=0 in WAIT and RESP; minimum request spacing `LATENCY`+1 cycles with `RespReady` tied high.
- `ReqValid` in WAIT/RESP is ignored (not queued); requester holds it until `ReqReady`.
- `RST` mid-operation: return to IDLE next edge; a store not yet committed is dropped; a committed store remains.
- `RST` has priority over every other event in the same cycle.

## Structure
- Shared package `dmem_pkg`: size encodings (`SIZE_BYTE`, `SIZE_HWORD`, `SIZE_WORD`), state enum, `MAX_LATENCY`=15.
- Sub-module `dmem_lane_align` (combinational): from addr[1:0], size, store data and stored word produce byte-enable mask, merged write word, right-justified read data, and alignment error.
- Top holds FSM, counter, request latch, RAM array.

## Test plan
- Word store 0xDEADBEEF to 0x100, then word load 0x100, `LATENCY`=2 -> `RespValid` 2 cycles after each accept, load `RespData`=0xDEADBEEF, `RespErr`=0.
- Byte stores 0x11,0x22,0x33,0x44 to 0x200..0x203, halfword load 0x202 -> 0x00004433; byte load 0x201 -> 0x00000022.
- Halfword load 0x101, word store 0x102 -> `RespErr`=1, `RespData`=0, word at 0x100 still 0xDEADBEEF; size 11 -> `RespErr`=1.
- Load address 4·`DEPTH_WORDS` -> `RespErr`=1; `RespReady` held low 5 cycles -> `RespValid`/`RespData` stable, `ReqReady`=0 throughout.
- `LATENCY`=1 back-to-back loads with `RespReady`=1 -> accepts every 2 cycles, response one cycle after each accept.
- Store to 0x300 accepted, `RST` pulsed one cycle before commit (`LATENCY`=4) -> outputs return to reset values, later load of 0x300 returns preloaded value.
